w5500_spi_reader: RTL

- SPI master that issues W5500 variable-length-data-mode read frames: 16-bit address, then control byte, then N data bytes.
- Presents the received bytes as a valid/ready byte stream.
- Sits directly upstream of the encryption core and is the source of its plaintext bytes.
- Owns o_spi_clk, o_spi_mosi and o_spi_cs, and samples i_spi_miso.

---
 rtl/w5500_pkg.sv | 28 ++
 rtl/spi_clk_gen.sv | 37 +++
 rtl/w5500_spi_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/w5500_pkg.sv
// Shared types and W5500 frame constants for the SPI read path.
package w5500_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_ADDR,
    S_CTRL,
    S_DATA,
    S_STALL,
    S_CS_HOLD,
    S_DONE
  } state_t;

  localparam logic       RWB_READ   = 1'b0;
  localparam logic [1:0] OM_VDM     = 2'b00;
  localparam logic [4:0] BSB_COMMON = 5'b00000;
  localparam logic [4:0] BSB_S0_REG = 5'b00001;
  localparam logic [4:0] BSB_S0_RX  = 5'b00011;
  localparam int         HDR_BITS   = 24;

  // Address phase followed by the variable-length-mode read control byte.
  function automatic logic [HDR_BITS-1:0] read_header(input logic [15:0] addr,
                                                      input logic [4:0]  bsb);
    return {addr, bsb, RWB_READ, OM_VDM};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Mode-0 SCLK generator: toggles every CLK_DIV clocks while enabled and
// flags the edge being produced; disabling parks SCLK low with a fresh count.
module spi_clk_gen
  import w5500_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc   = (cnt == CW'(CLK_DIV - 1));
  assign rise = en && tc && !sclk;
  assign fall = en && tc && sclk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/w5500_spi_reader.sv
// W5500 variable-length read master feeding a valid/ready byte stream.
// Optional W5500 hardware-reset sequencing is enabled with W5500_RST_EN.
module w5500_spi_reader
  import w5500_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int LEN_W      = 5,
  parameter int RST_CYCLES = 500
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [15:0]      i_addr,
  input  logic [4:0]       i_bsb,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_spi_miso,
  output logic             o_spi_mosi,
  output logic             o_spi_clk,
  output logic             o_spi_cs,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done
`ifdef W5500_RST_EN
  ,
  output logic             o_w5500_rst
`endif
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t              state, state_n;
  logic [CW-1:0]       wcnt;
  logic                wait_tc;
  logic [3:0]          bit_cnt;
  logic                last_bit;
  logic [LEN_W-1:0]    rem;
  logic [HDR_BITS-1:0] tx;
  logic [7:0]          rx;
  logic                cs;
  logic                sclk_en, rise, fall;
  logic                start_ok, rst_active;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (sclk_en),
    .sclk (o_spi_clk),
    .rise (rise),
    .fall (fall)
  );

`ifdef W5500_RST_EN
  localparam int RW = $clog2(RST_CYCLES + 1);
  logic [RW-1:0] rst_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)           rst_cnt <= '0;
    else if (rst_active) rst_cnt <= rst_cnt + 1'b1;
  end

  assign rst_active  = (rst_cnt != RW'(RST_CYCLES));
  assign o_w5500_rst = !rst_active;
`else
  localparam int unused_rst_cycles = RST_CYCLES;
  assign rst_active = 1'b0;
`endif

  assign sclk_en    = state inside {S_ADDR, S_CTRL, S_DATA};
  assign wait_tc    = (wcnt == CW'(CLK_DIV - 1));
  assign last_bit   = (state == S_ADDR) ? (bit_cnt == 4'd15) : (bit_cnt == 4'd7);
  assign start_ok   = i_start && (state == S_IDLE) && !rst_active;
  assign o_spi_cs   = cs;
  assign o_spi_mosi = tx[HDR_BITS-1];
  assign o_busy     = (state != S_IDLE) || rst_active;
  assign o_done     = (state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_n;
  end

  // Byte boundaries only advance when the previous byte has been taken,
  // which also protects an unread byte left over from an earlier read.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start_ok) state_n = (i_len == '0) ? S_DONE : S_CS_SETUP;
      S_CS_SETUP: if (wait_tc) state_n = S_ADDR;
      S_ADDR:     if (fall && last_bit) state_n = S_CTRL;
      S_CTRL:     if (fall && last_bit) state_n = (o_valid && !i_ready) ? S_STALL : S_DATA;
      S_DATA: begin
        if (fall && last_bit) begin
          if (rem == LEN_W'(1))          state_n = S_CS_HOLD;
          else if (o_valid && !i_ready)  state_n = S_STALL;
        end
      end
      S_STALL:    if (i_ready) state_n = S_DATA;
      S_CS_HOLD:  if (wait_tc) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt    <= '0;
      bit_cnt <= '0;
      rem     <= '0;
      tx      <= '0;
      rx      <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      cs      <= 1'b1;
    end else begin
      cs <= (state_n == S_IDLE) || (state_n == S_DONE);

      if ((state == S_CS_SETUP || state == S_CS_HOLD) && !wait_tc) wcnt <= wcnt + 1'b1;
      else                                                         wcnt <= '0;

      if (start_ok) begin
        rem     <= i_len;
        bit_cnt <= '0;
        if (i_len != '0) tx <= read_header(i_addr, i_bsb);
      end

      // Header shifts out fully, so MOSI is already 0 through DATA.
      if (fall) begin
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        if (state != S_DATA)                tx  <= {tx[HDR_BITS-2:0], 1'b0};
        else if (last_bit && rem != '0)     rem <= rem - 1'b1;
      end

      if (o_valid && i_ready) o_valid <= 1'b0;

      if (rise && state == S_DATA) begin
        rx <= {rx[6:0], i_spi_miso};
        if (bit_cnt == 4'd7) begin
          o_data  <= {rx[6:0], i_spi_miso};
          o_valid <= 1'b1;
        end
      end
    end
  end

endmodule
